// File: rtl/hex_sum_scan_display.sv
// hex_sum_scan_display
// Registers a WIDTH-bit sum a+b+cin (with carry out) and shows it in hex on a
// DIGITS-wide multiplexed common-anode seven-segment display. The carry out
// lights the decimal point of digit 0. Leading zero digits can be blanked.
//
// The pin registers are loaded from the next-state values of the sum and the
// digit index. As a result the pins always equal the decode of the current
// sum register and the current index. A capture or an index advance on an
// edge is therefore visible on the pins for the whole following cycle.
module hex_sum_scan_display #(
   parameter int WIDTH         = 8,
   parameter int DIGITS        = 4,
   parameter int SCAN_DIV      = 50000,
   parameter int LEADING_BLANK = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic              cin,
   input  logic              load,
   output logic [6:0]        seg,
   output logic              dp,
   output logic [DIGITS-1:0] an,
   output logic              sum_valid
);

   localparam int DW = 4 * DIGITS;
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   // Active-low segment pattern {CA..CG} for one hex nibble.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'h0:    pat = 7'b0000001;
         4'h1:    pat = 7'b1001111;
         4'h2:    pat = 7'b0010010;
         4'h3:    pat = 7'b0000110;
         4'h4:    pat = 7'b1001100;
         4'h5:    pat = 7'b0100100;
         4'h6:    pat = 7'b0100000;
         4'h7:    pat = 7'b0001111;
         4'h8:    pat = 7'b0000000;
         4'h9:    pat = 7'b0000100;
         4'hA:    pat = 7'b0001000;
         4'hB:    pat = 7'b1100000;
         4'hC:    pat = 7'b0110001;
         4'hD:    pat = 7'b1000010;
         4'hE:    pat = 7'b0110000;
         4'hF:    pat = 7'b0111000;
         default: pat = 7'b1111111;
      endcase
      return pat;
   endfunction

   logic [WIDTH:0]    sum_r;
   logic              valid_r;
   logic [PW-1:0]     presc_r;
   logic [IW-1:0]     idx_r;
   logic [6:0]        seg_r;
   logic              dp_r;
   logic [DIGITS-1:0] an_r;

   logic [WIDTH:0]    sum_nxt_s;
   logic [PW-1:0]     presc_nxt_s;
   logic [IW-1:0]     idx_nxt_s;
   logic [DW-1:0]     disp_s;
   logic [DW-1:0]     upper_s;
   logic [3:0]        nib_s;
   logic              blank_s;
   logic [6:0]        seg_nxt_s;
   logic              dp_nxt_s;
   logic [DIGITS-1:0] an_nxt_s;

   // Next sum: a load captures the full-width sum including carry out.
   always_comb begin
      sum_nxt_s = sum_r;
      if (load) begin
         sum_nxt_s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      end else begin
         sum_nxt_s = sum_r;
      end
   end

   // Next prescaler and digit index: the index advances when the prescaler wraps.
   always_comb begin
      presc_nxt_s = presc_r;
      idx_nxt_s   = idx_r;
      if (presc_r == PW'(SCAN_DIV - 1)) begin
         presc_nxt_s = {PW{1'b0}};
         if (idx_r == IW'(DIGITS - 1)) begin
            idx_nxt_s = {IW{1'b0}};
         end else begin
            idx_nxt_s = idx_r + IW'(1);
         end
      end else begin
         presc_nxt_s = presc_r + PW'(1);
         idx_nxt_s   = idx_r;
      end
   end

   // Pin values for the next cycle, decoded from the next sum and index.
   always_comb begin
      disp_s  = DW'(sum_nxt_s[WIDTH-1:0]);
      upper_s = disp_s >> {idx_nxt_s, 2'b00};
      nib_s   = upper_s[3:0];
      blank_s = 1'b0;
      if ((LEADING_BLANK != 0) && (idx_nxt_s != {IW{1'b0}}) && (upper_s == {DW{1'b0}})) begin
         blank_s = 1'b1;
      end else begin
         blank_s = 1'b0;
      end
      if (blank_s) begin
         seg_nxt_s = 7'b1111111;
      end else begin
         seg_nxt_s = hex_to_seg(nib_s);
      end
      an_nxt_s = ~(DIGITS'(1'b1) << idx_nxt_s);
      dp_nxt_s = ~((idx_nxt_s == {IW{1'b0}}) && sum_nxt_s[WIDTH]);
   end

   // State and pin registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_r   <= {(WIDTH+1){1'b0}};
         valid_r <= 1'b0;
         presc_r <= {PW{1'b0}};
         idx_r   <= {IW{1'b0}};
         seg_r   <= 7'b0000001;
         dp_r    <= 1'b1;
         an_r    <= ~DIGITS'(1'b1);
      end else begin
         sum_r   <= sum_nxt_s;
         valid_r <= valid_r | load;
         presc_r <= presc_nxt_s;
         idx_r   <= idx_nxt_s;
         seg_r   <= seg_nxt_s;
         dp_r    <= dp_nxt_s;
         an_r    <= an_nxt_s;
      end
   end

   assign seg       = seg_r;
   assign dp        = dp_r;
   assign an        = an_r;
   assign sum_valid = valid_r;

endmodule

// File: tb/tb_hex_sum_scan_display.sv
// Scoreboard bench for hex_sum_scan_display (WIDTH=8, DIGITS=4, SCAN_DIV=4).
// Two instances share inputs: one with leading-zero blanking, one without.
module tb_hex_sum_scan_display;

   localparam int W  = 8;
   localparam int DG = 4;
   localparam int SD = 4;

   logic         clk;
   logic         rst;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         load;
   logic [6:0]   seg1, seg0;
   logic         dp1, dp0;
   logic [DG-1:0] an1, an0;
   logic         v1, v0;

   hex_sum_scan_display #(.WIDTH(W), .DIGITS(DG), .SCAN_DIV(SD), .LEADING_BLANK(1)) dut_blank (
      .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .load(load),
      .seg(seg1), .dp(dp1), .an(an1), .sum_valid(v1));

   hex_sum_scan_display #(.WIDTH(W), .DIGITS(DG), .SCAN_DIV(SD), .LEADING_BLANK(0)) dut_full (
      .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .load(load),
      .seg(seg0), .dp(dp0), .an(an0), .sum_valid(v0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]    seg1;
      logic [6:0]    seg0;
      logic          dp;
      logic [DG-1:0] an;
      logic          v;
   } exp_t;

   exp_t q[$];

   int total = 0;
   int bad   = 0;

   logic [6:0] seg_tab [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   // Reference model: plain integer state of the display.
   int m_sum, m_presc, m_idx;
   bit m_valid;

   function automatic logic [6:0] exp_seg(int s, int idx, bit lb);
      int low;
      int upper;
      low   = s % 256;
      upper = low >> (4 * idx);
      if (lb && idx > 0 && upper == 0) return 7'b1111111;
      return seg_tab[upper % 16];
   endfunction

   function automatic exp_t expected();
      exp_t e;
      e.seg1 = exp_seg(m_sum, m_idx, 1'b1);
      e.seg0 = exp_seg(m_sum, m_idx, 1'b0);
      e.dp   = !(m_idx == 0 && ((m_sum >> 8) % 2) == 1);
      e.an   = ~(DG'(1) << m_idx);
      e.v    = m_valid;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
      end
   endtask

   // Monitor: every cycle the DUT presents pins; compare against the queue head.
   always @(negedge clk) begin
      if (!rst && q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("seg_blank", 32'(seg1), 32'(e.seg1));
         chk("seg_full",  32'(seg0), 32'(e.seg0));
         chk("dp_blank",  32'(dp1),  32'(e.dp));
         chk("dp_full",   32'(dp0),  32'(e.dp));
         chk("an_blank",  32'(an1),  32'(e.an));
         chk("an_full",   32'(an0),  32'(e.an));
         chk("valid",     32'(v1),   32'(e.v));
         chk("valid_full",32'(v0),   32'(e.v));
      end
   end

   // One clock: drive inputs, apply the model edge, push expectation, return at negedge.
   task automatic step(input bit ld, input int av, input int bv, input bit ci);
      a    = W'(av);
      b    = W'(bv);
      cin  = ci;
      load = ld;
      @(posedge clk);
      if (ld) begin
         m_sum   = (av % 256) + (bv % 256) + int'(ci);
         m_valid = 1'b1;
      end
      if (m_presc == SD - 1) begin
         m_presc = 0;
         m_idx   = (m_idx + 1) % DG;
      end else begin
         m_presc = m_presc + 1;
      end
      q.push_back(expected());
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0);
   endtask

   task automatic model_reset();
      m_sum = 0; m_presc = 0; m_idx = 0; m_valid = 1'b0;
   endtask

   // Asynchronous reset between edges, checked before any clock edge arrives.
   task automatic mid_reset();
      #3;
      rst = 1'b1;
      #1;
      chk("rst_an",    32'(an1),  32'(4'b1110));
      chk("rst_seg",   32'(seg1), 32'(7'b0000001));
      chk("rst_dp",    32'(dp1),  32'(1'b1));
      chk("rst_valid", 32'(v1),   32'(1'b0));
      chk("rst_seg_full", 32'(seg0), 32'(7'b0000001));
      q.delete();
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; a = '0; b = '0; cin = 1'b0; load = 1'b0;
      model_reset();
      #1;
      chk("init_an",  32'(an1),  32'(4'b1110));
      chk("init_seg", 32'(seg1), 32'(7'b0000001));
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Scan with no load: digit 0 "0", others blank / "0", sum_valid low.
      idle(20);

      // Hex sweep on digit 0, then 3+4.
      for (int v = 0; v < 16; v++) begin
         step(1'b1, v, 0, 1'b0);
         idle(16);
      end
      step(1'b1, 3, 4, 1'b0);
      idle(16);

      // Carry and cin.
      step(1'b1, 8'hFF, 8'h00, 1'b1);
      idle(16);
      step(1'b1, 8'h7F, 8'h01, 1'b0);
      idle(16);
      step(1'b1, 8'h0A, 8'h00, 1'b0);
      idle(16);

      // Reset mid-scan, then load exactly on a prescaler wrap.
      idle(6);
      mid_reset();
      idle(9);
      while (m_presc != SD - 1) step(1'b0, 0, 0, 1'b0);
      step(1'b1, 8'h5C, 8'h91, 1'b1);
      idle(8);

      // Random traffic, biased toward small sums to exercise blanking.
      for (int i = 0; i < 400; i++) begin
         int av, bv;
         bit ld;
         ld = ($urandom_range(0, 3) == 0);
         av = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 255);
         bv = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3)  : $urandom_range(0, 255);
         step(ld, av, bv, 1'($urandom_range(0, 1)));
         if (i == 200) mid_reset();
      end

      @(negedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule
